// File: rtl/my_nand2_pkg.sv
// Shared definitions for the clocked NAND primitive and its activity monitor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   DEF_WIDTH  - default operand width
//   DEF_CNT_W  - default transition-counter width
//   MAX_W      - widest operand the primitive accepts
//   vec_t      - MAX_W-wide vector used by nand_vec
//   nand_vec   - bitwise NAND of two vectors
package gate_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_W     = 64;

    typedef logic [MAX_W-1:0] vec_t;

    // Plain operator form so X/Z propagate with normal Verilog NAND rules:
    // a 0 on either input forces 1, otherwise an X/Z input yields X.
    // Callers narrower than MAX_W zero-extend their operands; the padded
    // bits come out as 1 and are cut off again by the caller's cast.
    function automatic vec_t nand_vec(input vec_t a, input vec_t b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/my_nand2_if.sv
// Operand/result bundle of the clocked NAND primitive.
// Latency: n/a (wires only).
// Backpressure: none; the primitive accepts new operands every cycle.
//
// Signals:
//   A, B       - operands (driven by the master)
//   Y          - combinational NAND of A and B
//   Y_q        - NAND result registered on the rising clock edge
//   y_changed  - one-cycle pulse when Y_q took a new value
//   chg_count  - saturating count of cycles in which Y_q changed
// Modports: master drives operands and observes results; slave is the gate.
interface my_nand2_if
    import gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_q;
    logic             y_changed;
    logic [CNT_W-1:0] chg_count;

    modport master (
        output A,
        output B,
        input  Y,
        input  Y_q,
        input  y_changed,
        input  chg_count
    );

    modport slave (
        input  A,
        input  B,
        output Y,
        output Y_q,
        output y_changed,
        output chg_count
    );

endinterface

// File: rtl/my_nand2_sat_counter.sv
// Saturating up-counter for activity statistics.
// Latency: count reflects inc one cycle after the edge that samples it.
// Backpressure: none; once at the maximum, further increments are dropped.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears count to 0
//   inc   - add one to count on this edge (unless saturated)
//   count - current count, holds at 2^CNT_W - 1
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        // Saturate instead of wrapping so a long-running monitor never
        // reports a small count after heavy activity.
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/my_nand2.sv
// Bitwise 2-input NAND with a zero-latency path and a registered, activity-counted mirror.
// Latency: Y is combinational; Y_q, y_changed and chg_count update one edge after the operands.
// Backpressure: none; operands are sampled every rising edge.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (Y_q -> all ones, pulse and count -> 0)
//   bus  - my_nand2_if.slave: A, B in; Y, Y_q, y_changed, chg_count out
module my_nand2
    import gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    my_nand2_if.slave      bus
);

    logic [WIDTH-1:0] y_nand;
    logic [WIDTH-1:0] y_q_q;
    logic [WIDTH-1:0] y_q_d;
    logic             y_changed_q;
    logic             y_changed_d;

    // Shared NAND result: feeds the output directly and is what the
    // register captures, so Y and Y_q can never disagree in function.
    assign y_nand = WIDTH'(nand_vec(MAX_W'(bus.A), MAX_W'(bus.B)));
    assign bus.Y  = y_nand;

    always_comb begin
        y_q_d       = y_nand;
        // Compare the value about to be captured with the one held now;
        // the pulse then lines up with the edge that changes Y_q.
        y_changed_d = |(y_q_d ^ y_q_q);
    end

    // All ones on reset: the NAND of idle 0/0 operands, so the first edge
    // after release with idle inputs is not counted as a transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_q       <= '1;
            y_changed_q <= 1'b0;
        end else begin
            y_q_q       <= y_q_d;
            y_changed_q <= y_changed_d;
        end
    end

    // Fed with the next-cycle pulse so the count already includes a change
    // in the same cycle that y_changed reports it.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_chg_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (y_changed_d),
        .count (bus.chg_count)
    );

    assign bus.Y_q       = y_q_q;
    assign bus.y_changed = y_changed_q;

endmodule

// File: tb/tb_my_nand2.sv
module tb_my_nand2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Two instances: scalar gate with a wide counter, byte gate with a 2-bit counter.
    my_nand2_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    my_nand2_if #(.WIDTH(8), .CNT_W(2))  if8 ();

    my_nand2 #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    my_nand2 #(.WIDTH(8), .CNT_W(2))  dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int yq1; int ch1; int cnt1;
        int yq8; int ch8; int cnt8;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state (registered view), plain integers.
    int m_yq1  = 1;
    int m_cnt1 = 0;
    int m_yq8  = 255;
    int m_cnt8 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_nand1(input int a, input int b);
        return (a == 1 && b == 1) ? 0 : 1;
    endfunction

    function automatic int ref_nand8(input int a, input int b);
        return 255 - (a & b);
    endfunction

    function automatic int sat_inc(input int c, input int max);
        return (c < max) ? c + 1 : c;
    endfunction

    // Called at negedge+1; applies operands, checks the combinational path,
    // optionally glitches the inputs, pushes the expected registered response
    // for the coming edge, then returns at the next negedge+1.
    task automatic step(input int a1, input int b1, input int a8, input int b8, input bit glitch);
        exp_t e;
        int n1, n8;
        if1.A = a1[0:0]; if1.B = b1[0:0];
        if8.A = a8[7:0]; if8.B = b8[7:0];
        #1;
        check("y1_comb", if1.Y, ref_nand1(a1, b1));
        check("y8_comb", if8.Y, ref_nand8(a8, b8));
        if (glitch) begin
            if1.A = ~if1.A;
            if8.A = 8'($urandom);
            if8.B = 8'($urandom);
            #1;
            if1.A = a1[0:0];
            if8.A = a8[7:0]; if8.B = b8[7:0];
        end
        n1 = ref_nand1(a1, b1);
        n8 = ref_nand8(a8, b8);
        e.ch1 = (n1 != m_yq1) ? 1 : 0;
        e.ch8 = (n8 != m_yq8) ? 1 : 0;
        if (e.ch1 == 1) m_cnt1 = sat_inc(m_cnt1, 65535);
        if (e.ch8 == 1) m_cnt8 = sat_inc(m_cnt8, 3);
        m_yq1 = n1; m_yq8 = n8;
        e.yq1 = m_yq1; e.cnt1 = m_cnt1;
        e.yq8 = m_yq8; e.cnt8 = m_cnt8;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: registered outputs are settled at the falling edge.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("yq1",   if1.Y_q,       mon_e.yq1);
            check("chg1",  if1.y_changed, mon_e.ch1);
            check("cnt1",  if1.chg_count, mon_e.cnt1);
            check("yq8",   if8.Y_q,       mon_e.yq8);
            check("chg8",  if8.y_changed, mon_e.ch8);
            check("cnt8",  if8.chg_count, mon_e.cnt8);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Truth table applied while reset is held: Y must not depend on it.
    int tt_a[5] = '{0, 0, 1, 1, 0};
    int tt_b[5] = '{0, 1, 0, 1, 0};
    int tt_y[5] = '{1, 1, 1, 0, 1};

    initial begin
        if1.A = '0; if1.B = '0;
        if8.A = '0; if8.B = '0;
        for (int i = 0; i < 5; i++) begin
            if1.A = tt_a[i][0:0];
            if1.B = tt_b[i][0:0];
            #1;
            check("truth_table", if1.Y, tt_y[i]);
            #9;
        end
        check("rst_yq1",  if1.Y_q,       1);
        check("rst_chg1", if1.y_changed, 0);
        check("rst_cnt1", if1.chg_count, 0);
        check("rst_yq8",  if8.Y_q,       8'hFF);
        check("rst_cnt8", if8.chg_count, 0);

        @(negedge clk);
        #1;
        rst = 1'b0;

        // Registered path and vector cases.
        step(0, 0, 8'h00, 8'h00, 1'b0);
        step(1, 1, 8'hF0, 8'hCC, 1'b0);
        step(1, 1, 8'hFF, 8'hFF, 1'b0);
        step(0, 1, 8'hFF, 8'hFF, 1'b0);
        step(1, 1, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset between edges: dut1 count is at 3 here.
        check("pre_rst_cnt1", if1.chg_count, 3);
        rst = 1'b1;
        #1;
        check("arst_yq1",  if1.Y_q,       1);
        check("arst_chg1", if1.y_changed, 0);
        check("arst_cnt1", if1.chg_count, 0);
        check("arst_yq8",  if8.Y_q,       8'hFF);
        check("arst_cnt8", if8.chg_count, 0);
        if1.A = 1'b1; if1.B = 1'b1;
        if8.A = 8'h5A; if8.B = 8'h0F;
        #1;
        check("arst_y1_tracks", if1.Y, 0);
        check("arst_y8_tracks", if8.Y, 8'hF5);
        if1.A = '0; if1.B = '0;
        if8.A = '0; if8.B = '0;
        m_yq1 = 1; m_cnt1 = 0; m_yq8 = 255; m_cnt8 = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Saturation of the 2-bit counter: every edge changes Y_q.
        for (int i = 0; i < 5; i++) begin
            step((i % 2 == 0) ? 1 : 0, 1, (i % 2 == 0) ? 1 : 0, 1, 1'b0);
        end

        // Randomized operands with mid-cycle glitches.
        for (int i = 0; i < 150; i++) begin
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        // Same-value operand swap: Y unchanged, so no pulse and no count.
        step(1, 0, 8'h0F, 8'hF0, 1'b0);
        step(0, 1, 8'hF0, 8'h0F, 1'b0);

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_nand2.md
Name: my_nand2

Overview:
- Bitwise 2-input NAND primitive with a combinational path and a registered path.
- Combinational output Y = ~(A & B), with zero latency. This is the path logic-level tests exercise.
- Registered mirror Y_q plus a saturating output-transition counter, used by the system monitor for activity statistics.
- Sits in the gate-primitive library. It is instantiated wherever a clocked NAND with activity tracking is needed.

Parameters:
- WIDTH, 1, bit width of A, B, Y, Y_q. Legal range is 1..64.
- CNT_W, 16, width of the transition counter.

Ports:
- clk  in  1  single clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Y  out  WIDTH  combinational NAND, ~(A & B).
- Y_q  out  WIDTH  registered NAND result.
- y_changed  out  1  registered pulse: high for one cycle when Y_q differs from its previous value.
- chg_count  out  CNT_W  saturating count of cycles in which Y_q changed.

Behaviour:
- Combinational path:
  - Y is purely combinational, with no dependence on clk or rst.
  - Y[i] = ~(A[i] & B[i]) for every bit.
  - Truth table per bit: 00 -> 1, 01 -> 1, 10 -> 1, 11 -> 0.
  - Y responds in the same timestep as an input change (zero-delay model).
- X/Z handling: follows standard Verilog NAND semantics.
  - Any bit with a 0 input gives 1.
  - Otherwise, an X or Z input gives X.
- Reset (rst high, asynchronous):
  - Y_q = all ones, which is the NAND of the 0/0 idle inputs.
  - y_changed = 0.
  - chg_count = 0.
  - Y is unaffected by reset.
- On each rising clk edge with rst low:
  - Y_q <= ~(A & B). Latency is 1 cycle.
  - y_changed <= 1 if the new Y_q differs from the current Y_q in any bit, else 0.
  - chg_count increments by 1 when the new y_changed is 1. It saturates at 2^CNT_W - 1 and never wraps.
- Boundary conditions:
  - Input changes between clock edges: only the value present at the edge is captured. Glitches are invisible to Y_q.
  - Reset asserted mid-operation clears Y_q, y_changed and chg_count immediately, without waiting for a clock edge.
  - First edge after reset release with A = B = 0: Y_q stays all ones and y_changed = 0.
  - Counter at maximum with a further change: chg_count holds at maximum and y_changed still pulses.
  - Simultaneous change of A and B that leaves Y unchanged: no pulse and no count.

Decomposition:
- Shared package (gate_pkg):
  - default WIDTH constant;
  - default CNT_W constant;
  - a function nand_vec(a, b), used by the combinational assign.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output count). It implements the saturating increment and can be reused by other activity monitors.

Test Plan:
- Truth table, WIDTH = 1, no clock dependence. Apply A/B = 0/0, then 0/1, then 1/0, then 1/1, then 0/0, at 10-time-unit spacing. Required Y = 1, 1, 1, 0, 1, each in the same timestep as its input change.
- Registered path:
  - Release reset with A = B = 0: Y_q = 1 after the first edge, y_changed = 0, chg_count = 0.
  - Set A = B = 1: after the next edge Y_q = 0, y_changed = 1, chg_count = 1.
  - Hold inputs: after the following edge y_changed = 0 and chg_count stays at 1.
- Async reset mid-run: after chg_count reaches 3, assert rst between edges. Y_q = 1, y_changed = 0 and chg_count = 0 immediately. Y still tracks A and B.
- Saturation, CNT_W = 2: toggle A between 0 and 1 with B = 1 for 5 edges. chg_count reads 1, 2, 3, 3, 3, and y_changed is high on every edge.
- Vector case, WIDTH = 8: A = 8'hF0, B = 8'hCC gives Y = 8'h3F. A = 8'hFF, B = 8'hFF gives Y = 8'h00. Y_q matches each value one edge later.
